// File: rtl/slow_clock_pkg.sv
// Shared constants and the output-mode encoding for the slow clock divider.
package slow_clock_pkg;

    localparam int CNT_WIDTH_DEF   = 26;
    localparam int DEFAULT_DIV_DEF = 5000000;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_t;

endpackage

// File: rtl/slow_clock_gen_if.sv
// Control and output bundle of the multi-channel slow clock divider.
interface slow_clock_gen_if #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 26
);
    logic [CHANNELS-1:0]           load;
    logic [CNT_WIDTH-1:0]          div_value;
    logic [CHANNELS-1:0]           enable;
    logic [CHANNELS-1:0]           mode;
    logic [CHANNELS-1:0]           divided_clock;
    logic [CHANNELS-1:0]           tick;
    logic [CHANNELS*CNT_WIDTH-1:0] clock_count;

    modport master (
        output load, div_value, enable, mode,
        input  divided_clock, tick, clock_count
    );

    modport slave (
        input  load, div_value, enable, mode,
        output divided_clock, tick, clock_count
    );
endinterface

// File: rtl/slow_clock_channel.sv
// One divider channel: up-counter with runtime terminal, square or pulse output.
module slow_clock_channel
    import slow_clock_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] div_value,
    input  logic                 enable,
    input  logic                 mode,
    output logic                 divided_clock,
    output logic                 tick,
    output logic [CNT_WIDTH-1:0] clock_count
);
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] term;
    logic                 pulse;
    logic                 at_term;

    assign pulse       = (mode_t'(mode) == MODE_PULSE);
    assign at_term     = (count == term);
    assign clock_count = count;

    // Load beats a coincident terminal event, so that event is dropped entirely.
    always_ff @(posedge clock) begin
        if (reset) begin
            count         <= '0;
            term          <= CNT_WIDTH'(DEFAULT_DIV);
            divided_clock <= 1'b0;
            tick          <= 1'b0;
        end else if (load) begin
            term  <= div_value;
            count <= '0;
            tick  <= 1'b0;
            if (pulse) divided_clock <= 1'b0;
        end else if (!enable) begin
            tick <= 1'b0;
            if (pulse) divided_clock <= 1'b0;
        end else if (at_term) begin
            count         <= '0;
            tick          <= 1'b1;
            divided_clock <= pulse ? 1'b1 : ~divided_clock;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
            if (pulse) divided_clock <= 1'b0;
        end
    end
endmodule

// File: rtl/slow_clock_gen.sv
// Multi-channel slow clock divider; each channel is an independent slow_clock_channel.
module slow_clock_gen
    import slow_clock_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clock,
    input  logic             reset,
    slow_clock_gen_if.slave  bus
);
    logic [CHANNELS-1:0]           divided_clock;
    logic [CHANNELS-1:0]           tick;
    logic [CHANNELS*CNT_WIDTH-1:0] clock_count;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        slow_clock_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clock         (clock),
            .reset         (reset),
            .load          (bus.load[i]),
            .div_value     (bus.div_value),
            .enable        (bus.enable[i]),
            .mode          (bus.mode[i]),
            .divided_clock (divided_clock[i]),
            .tick          (tick[i]),
            .clock_count   (clock_count[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    assign bus.divided_clock = divided_clock;
    assign bus.tick          = tick;
    assign bus.clock_count   = clock_count;
endmodule

// File: tb/tb_slow_clock_gen.sv
// Directed vector bench for slow_clock_gen with two 4-bit channels, reset terminal 3.
module tb_slow_clock_gen;

    localparam int CH = 2;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    slow_clock_gen_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) bus ();

    slow_clock_gen #(
        .CHANNELS    (CH),
        .CNT_WIDTH   (CW),
        .DEFAULT_DIV (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic [1:0] load;
        logic [3:0] dv;
        logic [1:0] en;
        logic [1:0] mode;
        logic [1:0] dclk;
        logic [1:0] tick;
        logic [3:0] c0;
        logic [3:0] c1;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic rst, input logic [1:0] load, input logic [3:0] dv,
                       input logic [1:0] en, input logic [1:0] mode,
                       input logic [1:0] dclk, input logic [1:0] tick,
                       input logic [3:0] c0, input logic [3:0] c1);
        vec_t v;
        v.rst = rst; v.load = load; v.dv = dv; v.en = en; v.mode = mode;
        v.dclk = dclk; v.tick = tick; v.c0 = c0; v.c1 = c1;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] load, input logic [3:0] dv,
                         input logic [1:0] en, input logic [1:0] mode);
        reset         = rst;
        bus.load      = load;
        bus.div_value = dv;
        bus.enable    = en;
        bus.mode      = mode;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; bus.load = '0; bus.div_value = '0; bus.enable = '0; bus.mode = '0;

        // reset, then ch0 square with default terminal 3
        add(1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        add(1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        add(0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);
        add(0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2, 0);
        add(0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3, 0);
        add(0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b01, 0, 0);
        add(0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b00, 1, 0);
        add(0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b00, 2, 0);
        add(0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b00, 3, 0);
        add(0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0);
        add(0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);
        // ch1 term=0 in pulse mode
        add(0, 2'b10, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2, 0);
        add(0, 2'b00, 0, 2'b11, 2'b10, 2'b10, 2'b10, 3, 0);
        add(0, 2'b00, 0, 2'b11, 2'b10, 2'b11, 2'b11, 0, 0);
        add(0, 2'b00, 0, 2'b11, 2'b10, 2'b11, 2'b10, 1, 0);
        // ch0 paused at count 2
        add(0, 2'b00, 0, 2'b01, 2'b10, 2'b01, 2'b00, 2, 0);
        for (int i = 0; i < 5; i++)
            add(0, 2'b00, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2, 0);
        add(0, 2'b00, 0, 2'b01, 2'b10, 2'b01, 2'b00, 3, 0);
        add(0, 2'b00, 0, 2'b01, 2'b10, 2'b00, 2'b01, 0, 0);
        add(0, 2'b00, 0, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0);
        add(0, 2'b00, 0, 2'b01, 2'b10, 2'b00, 2'b00, 2, 0);
        add(0, 2'b00, 0, 2'b01, 2'b10, 2'b00, 2'b00, 3, 0);
        // load on the terminal edge: no tick, no toggle, new terminal 5
        add(0, 2'b01, 5, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0);
        for (int k = 1; k <= 5; k++)
            add(0, 2'b00, 0, 2'b01, 2'b10, 2'b00, 2'b00, 4'(k), 0);
        add(0, 2'b00, 0, 2'b01, 2'b10, 2'b01, 2'b01, 0, 0);
        add(0, 2'b00, 0, 2'b01, 2'b10, 2'b01, 2'b00, 1, 0);
        add(0, 2'b00, 0, 2'b01, 2'b10, 2'b01, 2'b00, 2, 0);
        // mid-count reset restores terminal 3 on both channels
        add(1, 2'b00, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0);
        add(0, 2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1);
        add(0, 2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2, 2);
        add(0, 2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 3, 3);
        add(0, 2'b00, 0, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0);
        // ch0 mode switches square->pulse->square
        add(0, 2'b00, 0, 2'b11, 2'b00, 2'b11, 2'b00, 1, 1);
        add(0, 2'b00, 0, 2'b11, 2'b01, 2'b10, 2'b00, 2, 2);
        add(0, 2'b00, 0, 2'b11, 2'b01, 2'b10, 2'b00, 3, 3);
        add(0, 2'b00, 0, 2'b11, 2'b01, 2'b01, 2'b11, 0, 0);
        add(0, 2'b00, 0, 2'b11, 2'b00, 2'b01, 2'b00, 1, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].dv, vecs[i].en, vecs[i].mode);
            check($sformatf("v%0d divided_clock", i), 32'(bus.divided_clock), 32'(vecs[i].dclk));
            check($sformatf("v%0d tick", i),          32'(bus.tick),          32'(vecs[i].tick));
            check($sformatf("v%0d count0", i),        32'(bus.clock_count[3:0]), 32'(vecs[i].c0));
            check($sformatf("v%0d count1", i),        32'(bus.clock_count[7:4]), 32'(vecs[i].c1));
        end

        // all-ones terminal on ch0, ch1 left disabled holding count 1
        drive(0, 2'b01, 4'hF, 2'b01, 2'b00);
        check("max load count0", 32'(bus.clock_count[3:0]), 32'd0);
        check("max load tick",   32'(bus.tick), 32'd0);
        check("max load dclk0",  32'(bus.divided_clock[0]), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            drive(0, 2'b00, 4'h0, 2'b01, 2'b00);
            check($sformatf("max k%0d count0", k), 32'(bus.clock_count[3:0]), 32'(k % 16));
            check($sformatf("max k%0d tick0", k),  32'(bus.tick[0]), (k % 16 == 0) ? 32'd1 : 32'd0);
            check($sformatf("max k%0d dclk0", k),  32'(bus.divided_clock[0]), ((k / 16) % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("ch1 held count", 32'(bus.clock_count[7:4]), 32'd1);
        check("ch1 held dclk",  32'(bus.divided_clock[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
